matrix_engine_seq: RTL and testbench

Sequential, parametrised N x N matrix engine. Operand matrices A and B are loaded element-by-element over a write port. On a single start command the engine computes one of ADD, SUB, MUL (true row-by-column product via a single MAC) or TRANSPOSE_A. Results stream out in row-major order over a valid/ready handshake. It is the clocked successor to the team's combinational 3x3 matrix datapath and feeds downstream result consumers.

---
 rtl/matrix_pkg.sv | 24 ++
 rtl/matrix_mac.sv | 35 +++
 rtl/matrix_engine_seq.sv | 158 +++++++++++++++
 tb/tb_matrix_engine_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and width helper for the sequential matrix engine.
package matrix_pkg;

  // Operation selector, sampled together with start.
  typedef enum logic [1:0] {
    OP_ADD       = 2'b00,
    OP_SUB       = 2'b01,
    OP_MUL       = 2'b10,
    OP_TRANSPOSE = 2'b11
  } op_e;

  // Engine control states.
  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StEmit
  } state_e;

  // Result width: wide enough for N products of two DW-bit operands.
  function automatic int unsigned calc_rw(input int unsigned n, input int unsigned dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mac.sv
// Single multiply-accumulate unit: sum = acc + a*b, acc updated when enabled.
module matrix_mac #(
  parameter int unsigned DW = 4,
  parameter int unsigned RW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [RW-1:0] sum
);

  logic [2*DW-1:0] prod;
  logic [RW-1:0]   acc_q;

  // Product and running sum including the current term.
  always_comb begin
    prod = a * b;
    sum  = acc_q + RW'(prod);
  end

  // Accumulator register; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/matrix_engine_seq.sv
// Sequential N x N matrix engine: ADD, SUB, MUL (one MAC) or TRANSPOSE_A,
// results streamed row-major over a valid/ready handshake.
module matrix_engine_seq
  import matrix_pkg::*;
#(
  parameter int unsigned  N  = 3,
  parameter int unsigned  DW = 4,
  localparam int unsigned RW = calc_rw(N, DW),
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [IW-1:0] wr_row,
  input  logic [IW-1:0] wr_col,
  input  logic [DW-1:0] wr_data,
  input  logic [1:0]    op,
  input  logic          start,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic [IW-1:0] out_row,
  output logic [IW-1:0] out_col,
  output logic          done
);

  localparam logic [IW-1:0] Last = IW'(N - 1);

  state_e          state_q, state_d;
  op_e             op_q;
  logic [IW-1:0]   i_q, j_q, k_q;
  logic [RW-1:0]   out_data_q;
  logic            done_q;
  logic [DW-1:0]   a_q [N][N];
  logic [DW-1:0]   b_q [N][N];

  logic            wr_ok, hs, last_elem, calc_done, mac_clr, mac_en;
  logic [RW-1:0]   mac_sum, elem_res;
  logic [DW:0]     diff;

  // Handshake and sequencing conditions.
  always_comb begin
    wr_ok = wr_en && (state_q == StIdle) &&
            ({1'b0, wr_row} < (IW + 1)'(N)) && ({1'b0, wr_col} < (IW + 1)'(N));
    hs        = (state_q == StEmit) && out_ready;
    last_elem = (i_q == Last) && (j_q == Last);
    calc_done = (op_q != OP_MUL) || (k_q == Last);
    mac_clr   = ((state_q == StIdle) && start) || (hs && !last_elem);
    mac_en    = (state_q == StCalc) && (op_q == OP_MUL);
  end

  matrix_mac #(
    .DW (DW),
    .RW (RW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (a_q[i_q][k_q]),
    .b     (b_q[k_q][j_q]),
    .sum   (mac_sum)
  );

  // Element result for the current (i, j); SUB is sign-extended.
  always_comb begin
    diff     = {1'b0, a_q[i_q][j_q]} - {1'b0, b_q[i_q][j_q]};
    elem_res = '0;
    unique case (op_q)
      OP_ADD:       elem_res = RW'(a_q[i_q][j_q]) + RW'(b_q[i_q][j_q]);
      OP_SUB:       elem_res = {{(RW - DW - 1){diff[DW]}}, diff};
      OP_MUL:       elem_res = mac_sum;
      OP_TRANSPOSE: elem_res = RW'(a_q[j_q][i_q]);
    endcase
  end

  // Operand buffers; writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(N); r++) begin
        for (int c = 0; c < int'(N); c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (wr_sel) b_q[wr_row][wr_col] <= wr_data;
      else        a_q[wr_row][wr_col] <= wr_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (calc_done) state_d = StEmit;
      StEmit:  if (out_ready) state_d = last_elem ? StIdle : StCalc;
      default: state_d = StIdle;
    endcase
  end

  // Counters, latched op, result register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_ADD;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= hs && last_elem;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q <= op_e'(op);
            i_q  <= '0;
            j_q  <= '0;
            k_q  <= '0;
          end
        end
        StCalc: begin
          if (calc_done) out_data_q <= elem_res;
          else           k_q        <= k_q + 1'b1;
        end
        StEmit: begin
          if (hs && !last_elem) begin
            k_q <= '0;
            if (j_q == Last) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StEmit);
  assign out_data  = out_data_q;
  assign out_row   = i_q;
  assign out_col   = j_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_engine_seq.sv
// Self-checking bench for matrix_engine_seq against a plain-arithmetic model.
module tb_matrix_engine_seq;

  localparam int N  = 3;
  localparam int DW = 4;
  localparam int RW = 2 * DW + $clog2(N);
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, wr_sel, start, out_ready;
  logic [IW-1:0] wr_row, wr_col;
  logic [DW-1:0] wr_data;
  logic [1:0]    op;
  logic          busy, out_valid, done;
  logic [RW-1:0] out_data;
  logic [IW-1:0] out_row, out_col;

  int n_checks = 0;
  int n_fail   = 0;
  int ma [N][N];
  int mb [N][N];

  always #5 clk = ~clk;

  matrix_engine_seq #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .op        (op),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference result for element (r, c), reduced to RW bits.
  function automatic int model(input int o, input int r, input int c);
    int s = 0;
    case (o)
      0: s = ma[r][c] + mb[r][c];
      1: s = ma[r][c] - mb[r][c];
      2: for (int k = 0; k < N; k++) s += ma[r][k] * mb[k][c];
      default: s = ma[c][r];
    endcase
    return s & ((1 << RW) - 1);
  endfunction

  task automatic write_elem(input bit sel, input int r, input int c, input int d);
    wr_en = 1'b1; wr_sel = sel; wr_row = IW'(r); wr_col = IW'(c); wr_data = DW'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_elem(1'b0, r, c, ma[r][c]);
        write_elem(1'b1, r, c, mb[r][c]);
      end
  endtask

  // mode 0: ready always high, timing checked; 1: random ready;
  // 2: 5-cycle stall at element (1,1); 3: start/wr_en pokes while busy.
  // Edges are counted from the start edge as edge 0.
  task automatic run_op(input int o, input int mode);
    int idx = 0, cyc = 0, first_v = -1, early_done = 0, stall_left = 0;
    bit stall_used = 0;
    logic rdy;
    op = 2'(o); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx < N * N && cyc < 400) begin
      if (done) early_done++;
      if (mode == 3 && cyc == 1) begin
        check("busy_poke", busy, 1);
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 4'hf;
        start = 1'b1; op = 2'b00;
      end else if (mode == 3 && cyc == 2) begin
        wr_en = 1'b0; start = 1'b0;
      end
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        if (mode == 2 && idx == 4 && !stall_used) begin
          stall_left = 5; stall_used = 1;
        end
        if (stall_left > 0) begin
          rdy = 1'b0; stall_left--;
        end else rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        check("data", out_data, model(o, idx / N, idx % N));
        check("row", out_row, idx / N);
        check("col", out_col, idx % N);
        if (rdy) idx++;
      end else begin
        rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      out_ready = rdy;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    check("stream_complete", idx, N * N);
    check("no_early_done", early_done, 0);
    check("done_pulse", done, 1);
    if (mode == 0) begin
      check("first_valid_edge", first_v, (o == 2) ? N : 1);
      check("done_edge", cyc, (o == 2) ? N * N * (N + 1) : N * N * 2);
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after", busy, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_row"}, out_row, 0);
    check({tag, "_col"}, out_col, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int ndone;
    int plan_a [N][N] = '{'{6, 5, 7}, '{8, 11, 12}, '{6, 6, 1}};
    int plan_b [N][N] = '{'{2, 5, 3}, '{3, 9, 5}, '{2, 6, 10}};
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
    wr_data = '0; op = '0; start = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    ma = plan_a; mb = plan_b;
    load_all();
    run_op(2, 0);
    run_op(0, 0);
    run_op(1, 0);
    run_op(3, 0);
    run_op(2, 2);
    run_op(2, 3);
    run_op(3, 0);

    // Asynchronous reset in the middle of a MUL.
    op = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("reset_no_done", ndone, 0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = 0; mb[r][c] = 0;
      end
    run_op(2, 0);

    // Randomized operands, ops and back-pressure.
    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          ma[r][c] = $urandom_range(0, 15);
          mb[r][c] = $urandom_range(0, 15);
        end
      load_all();
      write_elem(1'b0, N, $urandom_range(0, N - 1), 15);
      write_elem(1'b1, $urandom_range(0, N - 1), N, 15);
      run_op($urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
